// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef enum logic {
    PRI_LS = 1'b0,
    PRI_IF = 1'b1
  } pri_e;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Read-response tracker: shifts each read's owner tag along so it emerges
// exactly RD_LATENCY cycles after the grant, lined up with mem_rdata.
module mem_arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  owner_e push_tag,
  output logic   pop_valid,
  output owner_e pop_tag
);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("mem_arb_resp_pipe: RD_LATENCY out of range 1..4");
  end

  logic [RD_LATENCY-1:0] valid_q;
  owner_e                tag_q [RD_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= OWN_IF;
    end else begin
      valid_q[0] <= push;
      tag_q[0]   <= push_tag;
      for (int i = 1; i < RD_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign pop_valid = valid_q[RD_LATENCY-1];
  assign pop_tag   = tag_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Alternating-priority arbiter sharing one memory port between fetch and load/store.
// Optional grant/conflict counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_if_grants,
  output logic [31:0]         stat_ls_grants,
  output logic [31:0]         stat_conflicts
`endif
);

  pri_e              state_q, state_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic              rd_push;
  owner_e            rd_tag;
  logic              resp_valid;
  owner_e            resp_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= PRI_LS;
    else          state_q <= state_d;
  end

  // Grants are gated by reset_n so every output reads 0 while reset is held.
  always_comb begin
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    state_d = state_q;
    if (reset_n) begin
      if (if_req && ls_req) begin
        if (state_q == PRI_IF) if_gnt = 1'b1;
        else                   ls_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
        ls_gnt = ls_req;
      end
    end
    if (if_gnt)      state_d = PRI_LS;
    else if (ls_gnt) state_d = PRI_IF;
  end

  always_comb begin
    mem_addr  = last_addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_we    = ls_we;
      mem_wdata = ls_wdata;
      mem_wmask = ls_wmask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              last_addr_q <= '0;
    else if (if_gnt || ls_gnt) last_addr_q <= mem_addr;
  end

  assign rd_push = if_gnt || (ls_gnt && !ls_we);
  assign rd_tag  = if_gnt ? OWN_IF : OWN_LS;

  mem_arb_resp_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_resp_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (rd_push),
    .push_tag (rd_tag),
    .pop_valid(resp_valid),
    .pop_tag  (resp_tag)
  );

  assign if_rvalid = resp_valid && (resp_tag == OWN_IF);
  assign ls_rvalid = resp_valid && (resp_tag == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
  // Saturating counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_if_grants <= '0;
      stat_ls_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      if (if_gnt && stat_if_grants != 32'hFFFF_FFFF)
        stat_if_grants <= stat_if_grants + 32'd1;
      if (ls_gnt && stat_ls_grants != 32'hFFFF_FFFF)
        stat_ls_grants <= stat_ls_grants + 32'd1;
      if (if_req && ls_req && stat_conflicts != 32'hFFFF_FFFF)
        stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: two arbiters (RD_LATENCY 1 and 3) share one stimulus
// stream and are compared each cycle against a queue-based reference model.
module tb_mem_arbiter;

  typedef struct {
    bit          own_ls;
    int          due;
    logic [31:0] data;
  } resp_t;

  logic        clk;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wmask;

  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        ls_gnt    [2];
  logic        ls_rvalid [2];
  logic [31:0] ls_rdata  [2];
  logic [31:0] mem_addr  [2];
  logic        mem_we    [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wmask [2];
  logic [31:0] mem_rdata [2];
`ifdef MEM_ARB_STATS_EN
  logic [31:0] st_if [2];
  logic [31:0] st_ls [2];
  logic [31:0] st_cf [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  bit          m_pri_if;
  logic [31:0] m_last_addr;
  logic [31:0] m_mem [256];
  resp_t       q1[$];
  resp_t       q3[$];
  int          m_if_cnt, m_ls_cnt, m_cf_cnt;

  function automatic logic [31:0] initWord(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0103;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two DUTs, each with its own simple memory whose data returns LAT cycles later
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem   [256];
    logic [31:0] rpipe [LAT];

    mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RD_LATENCY(LAT)
    ) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt[g]),
      .if_rvalid(if_rvalid[g]),
      .if_rdata (if_rdata[g]),
      .ls_req   (ls_req),
      .ls_we    (ls_we),
      .ls_addr  (ls_addr),
      .ls_wdata (ls_wdata),
      .ls_wmask (ls_wmask),
      .ls_gnt   (ls_gnt[g]),
      .ls_rvalid(ls_rvalid[g]),
      .ls_rdata (ls_rdata[g]),
      .mem_addr (mem_addr[g]),
      .mem_we   (mem_we[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_wmask(mem_wmask[g]),
      .mem_rdata(mem_rdata[g])
`ifdef MEM_ARB_STATS_EN
      ,
      .stat_if_grants(st_if[g]),
      .stat_ls_grants(st_ls[g]),
      .stat_conflicts(st_cf[g])
`endif
    );

    initial for (int i = 0; i < 256; i++) mem[i] <= initWord(i);

    always @(posedge clk) begin
      if (mem_we[g])
        mem[mem_addr[g][9:2]] <= merge(mem[mem_addr[g][9:2]], mem_wdata[g], mem_wmask[g]);
      rpipe[0] <= mem[mem_addr[g][9:2]];
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    assign mem_rdata[g] = rpipe[LAT-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    q1.delete();
    q3.delete();
    m_pri_if    = 1'b0;
    m_last_addr = '0;
    m_if_cnt    = 0;
    m_ls_cnt    = 0;
    m_cf_cnt    = 0;
  endtask

  // Compares both DUTs against the model for the current cycle, then advances the model
  task automatic checkOutput(input bit rst);
    bit          eg_if, eg_ls, hit;
    logic [31:0] ea, ewd;
    logic [3:0]  ewm;
    bit          ewe;
    resp_t       fr;
    string       p;

    eg_if = 0; eg_ls = 0; ea = '0; ewd = '0; ewm = '0; ewe = 0;
    if (rst) begin
      modelReset();
    end else begin
      if (if_req && ls_req) begin
        eg_if = m_pri_if;
        eg_ls = !m_pri_if;
      end else begin
        eg_if = if_req;
        eg_ls = ls_req;
      end
      ea  = eg_if ? if_addr : (eg_ls ? ls_addr : m_last_addr);
      ewe = eg_ls && ls_we;
      ewd = eg_ls ? ls_wdata : '0;
      ewm = eg_ls ? ls_wmask : '0;
    end

    for (int g = 0; g < 2; g++) begin
      p   = (g == 0) ? "L1" : "L3";
      hit = 0;
      fr  = '{own_ls: 1'b0, due: 0, data: '0};
      if (g == 0) begin
        if (q1.size() > 0 && q1[0].due == cyc) begin hit = 1; fr = q1.pop_front(); end
      end else begin
        if (q3.size() > 0 && q3[0].due == cyc) begin hit = 1; fr = q3.pop_front(); end
      end
      chk({p, " if_gnt"},    32'(if_gnt[g]),    32'(eg_if));
      chk({p, " ls_gnt"},    32'(ls_gnt[g]),    32'(eg_ls));
      chk({p, " mem_addr"},  mem_addr[g],       ea);
      chk({p, " mem_we"},    32'(mem_we[g]),    32'(ewe));
      chk({p, " mem_wdata"}, mem_wdata[g],      ewd);
      chk({p, " mem_wmask"}, 32'(mem_wmask[g]), 32'(ewm));
      chk({p, " if_rvalid"}, 32'(if_rvalid[g]), 32'(hit && !fr.own_ls));
      chk({p, " if_rdata"},  if_rdata[g],       (hit && !fr.own_ls) ? fr.data : 32'h0);
      chk({p, " ls_rvalid"}, 32'(ls_rvalid[g]), 32'(hit && fr.own_ls));
      chk({p, " ls_rdata"},  ls_rdata[g],       (hit && fr.own_ls) ? fr.data : 32'h0);
`ifdef MEM_ARB_STATS_EN
      chk({p, " stat_if"}, st_if[g], 32'(m_if_cnt));
      chk({p, " stat_ls"}, st_ls[g], 32'(m_ls_cnt));
      chk({p, " stat_cf"}, st_cf[g], 32'(m_cf_cnt));
`endif
    end

    if (!rst) begin
      if (eg_if || eg_ls) m_last_addr = ea;
      if (eg_if)      m_pri_if = 1'b0;
      else if (eg_ls) m_pri_if = 1'b1;
      if (eg_if || (eg_ls && !ls_we)) begin
        q1.push_back('{own_ls: eg_ls, due: cyc + 1, data: m_mem[ea[9:2]]});
        q3.push_back('{own_ls: eg_ls, due: cyc + 3, data: m_mem[ea[9:2]]});
      end
      if (ewe) m_mem[ea[9:2]] = merge(m_mem[ea[9:2]], ewd, ewm);
      if (eg_if) m_if_cnt++;
      if (eg_ls) m_ls_cnt++;
      if (if_req && ls_req) m_cf_cnt++;
    end
    cyc++;
  endtask

  task automatic applyStimulus(input bit rst, input bit ifr, input logic [31:0] ifa,
                               input bit lsr, input bit lswe, input logic [31:0] lsa,
                               input logic [31:0] wd, input logic [3:0] wm);
    reset_n  = !rst;
    if_req   = ifr;
    if_addr  = ifa;
    ls_req   = lsr;
    ls_we    = lswe;
    ls_addr  = lsa;
    ls_wdata = wd;
    ls_wmask = wm;
    @(negedge clk);
    checkOutput(rst);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = initWord(i);
    modelReset();
    reset_n = 1'b0;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);

    $display("[TB] both requesters contending");
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 32'h10 + 32'(i) * 4, 1, 0, 32'h20 + 32'(i) * 4, '0, '0);
    idle(4);

    $display("[TB] back-to-back fetches");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'(i) * 4, 0, 0, '0, '0, '0);
    idle(4);

    $display("[TB] store then load");
    applyStimulus(0, 0, '0, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(0, 0, '0, 1, 0, 32'h100, '0, '0);
    idle(4);

    $display("[TB] alternating fetch / load reads");
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) applyStimulus(0, 1, 32'h40 + 32'(i) * 4, 0, 0, '0, '0, '0);
      else            applyStimulus(0, 0, '0, 1, 0, 32'h40 + 32'(i) * 4, '0, '0);
    end
    idle(4);

    $display("[TB] reset with read in flight");
    applyStimulus(0, 0, '0, 1, 0, 32'h80, '0, '0);
    idle(1);
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);
    idle(4);
    applyStimulus(0, 1, 32'h84, 1, 0, 32'h88, '0, '0);
    idle(4);

    $display("[TB] ten conflict cycles after reset");
    applyStimulus(1, 0, '0, 0, 0, '0, '0, '0);
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, 32'h200 + 32'(i) * 4, 1, 0, 32'h300 + 32'(i) * 4, '0, '0);
    idle(4);
`ifdef MEM_ARB_STATS_EN
    for (int g = 0; g < 2; g++) begin
      chk("stat_conflicts after 10", st_cf[g], 32'd10);
      chk("stat_if_grants after 10", st_if[g], 32'd5);
      chk("stat_ls_grants after 10", st_ls[g], 32'd5);
    end
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 63) == 0,
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 255)) << 2, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
